// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants and saturation-limit helpers.
package ldpc_pkg;

    // Default signed width of LLRs and check-node messages.
    localparam int unsigned W_DEFAULT = 10;

    // Guard bits added above W so a sum of four W-bit terms cannot overflow.
    localparam int unsigned GUARD_W = 2;

    // Largest positive value representable in w-bit two's complement.
    function automatic int sat_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative value representable in w-bit two's complement.
    function automatic int sat_min(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/sat_clip_w2.sv
// Saturates a (W+GUARD_W)-bit signed value to W bits and reports whether it clipped.
module sat_clip_w2
    import ldpc_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [W+GUARD_W-1:0] x,
    output logic [W-1:0]         y_c,
    output logic                 clip_c
);

    localparam logic [W-1:0] MAX_V = W'(sat_max(W));
    localparam logic [W-1:0] MIN_V = W'(sat_min(W));

    // Guard bits plus the W-bit sign bit; all-equal means the value fits in W bits.
    logic [GUARD_W:0] top_c;
    assign top_c = x[W+GUARD_W-1:W-1];

    // Pass through when in range, otherwise clip toward the sign of x.
    always_comb begin
        y_c    = x[W-1:0];
        clip_c = 1'b0;
        if ((top_c != '0) && (top_c != '1)) begin
            clip_c = 1'b1;
            y_c    = x[W+GUARD_W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/vnu_extrinsic_sub_pipelined.sv
// Variable-node back-end: total = llr + sum(msg), ext_k = sat(total - msg_k),
// hard decision from the sign of total. Two-stage valid/ready pipeline.
module vnu_extrinsic_sub_pipelined
    import ldpc_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] llr_ch,
    input  logic [W-1:0] msg0,
    input  logic [W-1:0] msg1,
    input  logic [W-1:0] msg2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] ext0,
    output logic [W-1:0] ext1,
    output logic [W-1:0] ext2,
    output logic         hard_bit,
    output logic [2:0]   sat_flag
);

    localparam int unsigned WG = W + GUARD_W;

    logic          s1_valid;
    logic          s1_en_c;
    logic          s2_en_c;
    logic [WG-1:0] tot_c;
    logic [WG-1:0] tot_q;
    logic [W-1:0]  m_q [3];
    logic [WG-1:0] e_c [3];
    logic [W-1:0]  sat_c [3];
    logic [2:0]    clip_c;

    // Stall chain: a stage may load when it is empty or the stage after it moves.
    assign s2_en_c  = !out_valid || out_ready;
    assign s1_en_c  = !s1_valid || s2_en_c;
    assign in_ready = s1_en_c;

    // Four-way sign-extended sum; the guard bits hold the full range exactly.
    assign tot_c = {{GUARD_W{llr_ch[W-1]}}, llr_ch}
                 + {{GUARD_W{msg0[W-1]}}, msg0}
                 + {{GUARD_W{msg1[W-1]}}, msg1}
                 + {{GUARD_W{msg2[W-1]}}, msg2};

    // Stage 1: register total and the messages needed for the extrinsic subtraction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            tot_q    <= '0;
            m_q[0]   <= '0;
            m_q[1]   <= '0;
            m_q[2]   <= '0;
        end else if (s1_en_c) begin
            s1_valid <= in_valid;
            tot_q    <= tot_c;
            m_q[0]   <= msg0;
            m_q[1]   <= msg1;
            m_q[2]   <= msg2;
        end
    end

    // Extrinsic = total minus own message, then saturate back to W bits.
    for (genvar k = 0; k < 3; k++) begin : g_ext
        assign e_c[k] = tot_q - {{GUARD_W{m_q[k][W-1]}}, m_q[k]};

        sat_clip_w2 #(
            .W (W)
        ) u_sat (
            .x      (e_c[k]),
            .y_c    (sat_c[k]),
            .clip_c (clip_c[k])
        );
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            ext0      <= '0;
            ext1      <= '0;
            ext2      <= '0;
            hard_bit  <= 1'b0;
            sat_flag  <= '0;
        end else if (s2_en_c) begin
            out_valid <= s1_valid;
            ext0      <= sat_c[0];
            ext1      <= sat_c[1];
            ext2      <= sat_c[2];
            hard_bit  <= tot_q[WG-1];
            sat_flag  <= clip_c;
        end
    end

endmodule
